aq_gemac_pfc_ctrl: RTL and testbench
====================================

Name: aq_gemac_pfc_ctrl

Overview:
- Parametrised successor to the single-class 802.3x flow-control block: per-priority (802.1Qbb PFC) pause timers for NUM_CLASS traffic classes.
- Loads class quanta from received PFC frames or legacy PAUSE frames, counts them down in 512-bit-time units and drives one pause-apply line per class to the TX scheduler.
- Sits in the CLK domain between the RX MAC pause-decode outputs (already synchronised) and the TX MAC / TX buffer arbitration.

Parameters:
- NUM_CLASS, 8, number of priority classes (1..8).
- QUANTA_W, 16, pause quanta width in bits.
- QUANTA_CYCLES_GIG, 64, CLK cycles per quanta when GIG_MODE=1.
- QUANTA_CYCLES_MII, 128, CLK cycles per quanta when GIG_MODE=0.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- GIG_MODE  in  1  selects the prescaler period.
- TX_PAUSE_ENABLE  in  1  global enable for honouring received pause.
- RX_PFC_VALID  in  1  one-cycle pulse: PFC frame decoded.
- RX_PFC_MASK  in  NUM_CLASS  class-enable vector from the PFC frame.
- RX_PFC_QUANTA  in  NUM_CLASS*QUANTA_W  per-class quanta; class i occupies bits [i*QUANTA_W +: QUANTA_W].
- RX_PAUSE_VALID  in  1  one-cycle pulse: legacy 802.3x PAUSE frame decoded.
- RX_PAUSE_QUANTA  in  QUANTA_W  legacy quanta.
- TX_ACTIVE  in  NUM_CLASS  class i currently has a frame on the wire.
- PAUSE_APPLY  out  NUM_CLASS  class i must not start a new frame.
- PAUSE_ANY  out  1  OR of PAUSE_APPLY.
- PAUSE_LOAD_DONE  out  1  one-cycle pulse when any timer was loaded.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - all timers = 0, prescaler = 0;
  - PAUSE_APPLY = 0, PAUSE_ANY = 0, PAUSE_LOAD_DONE = 0.
- Prescaler:
  - Free-running counter 0..P-1, where P = QUANTA_CYCLES_GIG if GIG_MODE else QUANTA_CYCLES_MII.
  - tick = (count == P-1).
  - A registered copy of GIG_MODE is kept; on any change of GIG_MODE the count is forced to 0 that cycle and no tick is issued.
  - Width: clog2 of the larger period.
- Timer i (QUANTA_W bits), priority order per cycle:
  1. TX_PAUSE_ENABLE=0 -> cleared to 0. All loads are ignored.
  2. RX_PFC_VALID and RX_PFC_MASK[i] -> load RX_PFC_QUANTA slice i. This replaces the current value, larger or smaller.
  3. RX_PAUSE_VALID -> load RX_PAUSE_QUANTA into every class.
  4. tick and timer != 0 -> decrement by 1.
- Load/tick interaction:
  - A load overrides a tick in the same cycle.
  - RX_PFC_VALID takes priority over RX_PAUSE_VALID if both pulse together. Classes outside the mask then take the legacy value.
  - A load of 0 releases the class on the next cycle.
- PAUSE_APPLY[i] register:
  - set when timer_i != 0 and TX_ACTIVE[i] = 0. Deferral: an in-flight frame is never truncated.
  - cleared when timer_i == 0.
  - otherwise holds.
- Latency:
  - Load at edge N: timer valid after N, PAUSE_APPLY high after edge N+1 if the class is idle.
  - If TX_ACTIVE[i]=1, assertion is delayed to the cycle after TX_ACTIVE[i] falls, provided the timer is still nonzero.
  - Release: PAUSE_APPLY falls one edge after the timer reaches 0.
- Pause duration: effective duration = quanta*P - prescaler phase at load (± one cycle). The timer is not resynchronised to the load.
- PAUSE_ANY is combinational OR of the PAUSE_APPLY register bits.
- PAUSE_LOAD_DONE is registered: high one cycle after any accepted load.
- Mid-operation conditions:
  - Reset mid-count returns to the reset state in one edge.
  - Deasserting TX_PAUSE_ENABLE clears all timers; PAUSE_APPLY drops one edge later.

Optional Feature:
- Macro AQ_GEMAC_PFC_STATS_EN.
- With the macro defined, the block adds:
  - input STAT_SEL [2:0];
  - input STAT_CLR (1);
  - output STAT_DATA [15:0];
  - per-class 16-bit saturating counters of accepted nonzero loads.
- Counter behaviour:
  - STAT_DATA = counter[STAT_SEL], registered, 1-cycle latency.
  - STAT_CLR zeroes all counters; an increment in the same cycle is lost.
  - Counters saturate at 16'hFFFF.
  - RST clears all counters.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package aq_gemac_pkg:
  - localparams QUANTA_BIT_TIMES=512, default QUANTA_W, MAX_CLASS=8;
  - function clog2.
- One sub-module, aq_gemac_pfc_timer: a single-class timer plus apply flag, instantiated NUM_CLASS times by generate.
- Prescaler and load arbitration stay in the top.

Test Plan:
- PFC load, idle class: reset, GIG_MODE=1. At prescaler count 0, pulse RX_PFC_VALID with mask 8'h08 and class-3 quanta 2 -> PAUSE_APPLY=8'h08 from edge N+1; timer hits 0 after 128 cycles; PAUSE_APPLY falls at 129±1. Other classes stay 0.
- Deferral: TX_ACTIVE[1]=1, PFC mask 8'h02 quanta 10, drop TX_ACTIVE[1] 20 cycles later -> PAUSE_APPLY[1] rises exactly 1 edge after the drop.
- Override: class 0 loaded with 100, then reloaded with 0 after 50 cycles -> PAUSE_APPLY[0] falls 2 edges after the second load.
- Legacy plus simultaneous load:
  - RX_PAUSE_VALID quanta 5 alone -> all 8 bits high, PAUSE_ANY=1.
  - Both valids together with PFC mask 8'h01 quanta 1, legacy quanta 7 -> class 0 = 1, classes 1-7 = 7.
- Mode/enable: GIG_MODE=0, quanta 1 -> apply lasts 128 cycles. Toggle TX_PAUSE_ENABLE low mid-count -> PAUSE_APPLY=0 after 2 edges; subsequent loads are ignored.
- Stats (AQ_GEMAC_PFC_STATS_EN):
  - 3 nonzero loads on class 2 -> STAT_SEL=2 reads 3;
  - STAT_CLR -> reads 0;
  - preset counter to 16'hFFFF by force, apply one more load -> stays 16'hFFFF.

Source files
------------

// File: rtl/aq_gemac_pkg.sv
// Shared constants and helpers for the GEMAC priority flow-control blocks.
package aq_gemac_pkg;

    // One pause quantum is defined as 512 bit times on the wire.
    localparam int QUANTA_BIT_TIMES = 512;
    localparam int DEFAULT_QUANTA_W = 16;
    localparam int MAX_CLASS        = 8;

    // Ceiling log2. The loop is bounded so that it elaborates as a constant.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/aq_gemac_pfc_timer.sv
// Single-class pause timer plus its deferred pause-apply flag.
module aq_gemac_pfc_timer
    import aq_gemac_pkg::*;
#(
    parameter int QUANTA_W = DEFAULT_QUANTA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [QUANTA_W-1:0] load_val,
    input  logic                tick,
    input  logic                tx_active,
    output logic                apply
);

    logic [QUANTA_W-1:0] timer_q, timer_d;
    logic                apply_q, apply_d;

    // Timer update: clear beats load, load beats the quanta tick.
    always_comb begin
        timer_d = timer_q;
        if (clr) begin
            timer_d = '0;
        end else if (load) begin
            timer_d = load_val;
        end else if (tick && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end
    end

    // Apply flag: never raised while a frame is in flight, so the wire frame completes.
    always_comb begin
        apply_d = apply_q;
        if (timer_q == '0) begin
            apply_d = 1'b0;
        end else if (!tx_active) begin
            apply_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            apply_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            apply_q <= apply_d;
        end
    end

    assign apply = apply_q;

endmodule

// File: rtl/aq_gemac_pfc_ctrl.sv
// Per-priority (PFC) pause controller: prescaler, load arbitration and one
// timer per traffic class. Optional per-class load statistics are built when
// the macro AQ_GEMAC_PFC_STATS_EN is defined.
module aq_gemac_pfc_ctrl
    import aq_gemac_pkg::*;
#(
    parameter int NUM_CLASS         = 8,
    parameter int QUANTA_W          = DEFAULT_QUANTA_W,
    parameter int QUANTA_CYCLES_GIG = 64,
    parameter int QUANTA_CYCLES_MII = 128
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          GIG_MODE,
    input  logic                          TX_PAUSE_ENABLE,
    input  logic                          RX_PFC_VALID,
    input  logic [NUM_CLASS-1:0]          RX_PFC_MASK,
    input  logic [NUM_CLASS*QUANTA_W-1:0] RX_PFC_QUANTA,
    input  logic                          RX_PAUSE_VALID,
    input  logic [QUANTA_W-1:0]           RX_PAUSE_QUANTA,
    input  logic [NUM_CLASS-1:0]          TX_ACTIVE,
    output logic [NUM_CLASS-1:0]          PAUSE_APPLY,
    output logic                          PAUSE_ANY,
    output logic                          PAUSE_LOAD_DONE
`ifdef AQ_GEMAC_PFC_STATS_EN
    ,
    input  logic [2:0]                    STAT_SEL,
    input  logic                          STAT_CLR,
    output logic [15:0]                   STAT_DATA
`endif
);

    localparam int PRESC_MAX = (QUANTA_CYCLES_GIG > QUANTA_CYCLES_MII) ?
                               QUANTA_CYCLES_GIG : QUANTA_CYCLES_MII;
    localparam int PRESC_W   = (clog2(PRESC_MAX) < 1) ? 1 : clog2(PRESC_MAX);
    localparam logic [PRESC_W-1:0] LAST_GIG = PRESC_W'(QUANTA_CYCLES_GIG - 1);
    localparam logic [PRESC_W-1:0] LAST_MII = PRESC_W'(QUANTA_CYCLES_MII - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               gig_q, gig_d;
    logic               load_done_q, load_done_d;
    logic               mode_chg;
    logic               tick;
    logic [PRESC_W-1:0] presc_last;

    logic                               tmr_clr;
    logic [NUM_CLASS-1:0]               ld_en;
    logic [NUM_CLASS-1:0][QUANTA_W-1:0] ld_val;
    logic [NUM_CLASS-1:0]               apply_w;

    // Quanta prescaler: restarts from 0 without a tick whenever the speed mode flips.
    always_comb begin
        gig_d      = GIG_MODE;
        mode_chg   = (GIG_MODE != gig_q);
        presc_last = GIG_MODE ? LAST_GIG : LAST_MII;
        tick       = !mode_chg && (presc_q == presc_last);
        if (mode_chg || (presc_q >= presc_last)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Load arbitration: PFC classes in the mask win, everyone else takes a legacy PAUSE.
    always_comb begin
        tmr_clr = !TX_PAUSE_ENABLE;
        for (int i = 0; i < NUM_CLASS; i++) begin
            ld_en[i]  = 1'b0;
            ld_val[i] = '0;
            if (TX_PAUSE_ENABLE) begin
                if (RX_PFC_VALID && RX_PFC_MASK[i]) begin
                    ld_en[i]  = 1'b1;
                    ld_val[i] = RX_PFC_QUANTA[i*QUANTA_W +: QUANTA_W];
                end else if (RX_PAUSE_VALID) begin
                    ld_en[i]  = 1'b1;
                    ld_val[i] = RX_PAUSE_QUANTA;
                end
            end
        end
        load_done_d = |ld_en;
    end

    // Prescaler, mode shadow and load strobe registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q     <= '0;
            gig_q       <= gig_d;
            load_done_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            gig_q       <= gig_d;
            load_done_q <= load_done_d;
        end
    end

    for (genvar i = 0; i < NUM_CLASS; i++) begin : g_cls
        aq_gemac_pfc_timer #(
            .QUANTA_W (QUANTA_W)
        ) u_tmr (
            .clk       (CLK),
            .rst       (RST),
            .clr       (tmr_clr),
            .load      (ld_en[i]),
            .load_val  (ld_val[i]),
            .tick      (tick),
            .tx_active (TX_ACTIVE[i]),
            .apply     (apply_w[i])
        );
    end

    assign PAUSE_APPLY     = apply_w;
    assign PAUSE_ANY       = |apply_w;
    assign PAUSE_LOAD_DONE = load_done_q;

`ifdef AQ_GEMAC_PFC_STATS_EN
    logic [NUM_CLASS-1:0][15:0] stat_cnt_q, stat_cnt_d;
    logic [15:0]                stat_data_q, stat_data_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count accepted nonzero loads per class; a clear swallows a coincident increment.
    always_comb begin
        for (int i = 0; i < NUM_CLASS; i++) begin
            stat_cnt_d[i] = stat_cnt_q[i];
            if (STAT_CLR) begin
                stat_cnt_d[i] = '0;
            end else if (ld_en[i] && (ld_val[i] != '0)) begin
                stat_cnt_d[i] = sat_inc(stat_cnt_q[i]);
            end
        end
        stat_data_d = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (int'(STAT_SEL) == i) begin
                stat_data_d = stat_cnt_q[i];
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_cnt_q  <= '0;
            stat_data_q <= '0;
        end else begin
            stat_cnt_q  <= stat_cnt_d;
            stat_data_q <= stat_data_d;
        end
    end

    assign STAT_DATA = stat_data_q;
`endif

endmodule

// File: tb/tb_aq_gemac_pfc_ctrl.sv
// Directed testbench for aq_gemac_pfc_ctrl (8 classes, 16-bit quanta, 64/128 prescale).
// Statistics checks are compiled when AQ_GEMAC_PFC_STATS_EN is defined.
module tb_aq_gemac_pfc_ctrl;

    logic         CLK;
    logic         RST;
    logic         GIG_MODE;
    logic         TX_PAUSE_ENABLE;
    logic         RX_PFC_VALID;
    logic [7:0]   RX_PFC_MASK;
    logic [127:0] RX_PFC_QUANTA;
    logic         RX_PAUSE_VALID;
    logic [15:0]  RX_PAUSE_QUANTA;
    logic [7:0]   TX_ACTIVE;
    logic [7:0]   PAUSE_APPLY;
    logic         PAUSE_ANY;
    logic         PAUSE_LOAD_DONE;
`ifdef AQ_GEMAC_PFC_STATS_EN
    logic [2:0]   STAT_SEL;
    logic         STAT_CLR;
    logic [15:0]  STAT_DATA;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    aq_gemac_pfc_ctrl #(
        .NUM_CLASS         (8),
        .QUANTA_W          (16),
        .QUANTA_CYCLES_GIG (64),
        .QUANTA_CYCLES_MII (128)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .GIG_MODE        (GIG_MODE),
        .TX_PAUSE_ENABLE (TX_PAUSE_ENABLE),
        .RX_PFC_VALID    (RX_PFC_VALID),
        .RX_PFC_MASK     (RX_PFC_MASK),
        .RX_PFC_QUANTA   (RX_PFC_QUANTA),
        .RX_PAUSE_VALID  (RX_PAUSE_VALID),
        .RX_PAUSE_QUANTA (RX_PAUSE_QUANTA),
        .TX_ACTIVE       (TX_ACTIVE),
        .PAUSE_APPLY     (PAUSE_APPLY),
        .PAUSE_ANY       (PAUSE_ANY),
        .PAUSE_LOAD_DONE (PAUSE_LOAD_DONE)
`ifdef AQ_GEMAC_PFC_STATS_EN
        ,
        .STAT_SEL        (STAT_SEL),
        .STAT_CLR        (STAT_CLR),
        .STAT_DATA       (STAT_DATA)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pfc(input logic [7:0] m, input int idx, input logic [15:0] q);
        RX_PFC_VALID  = 1'b1;
        RX_PFC_MASK   = m;
        RX_PFC_QUANTA = '0;
        RX_PFC_QUANTA[idx*16 +: 16] = q;
    endtask

    task automatic idle_rx();
        RX_PFC_VALID    = 1'b0;
        RX_PFC_MASK     = '0;
        RX_PFC_QUANTA   = '0;
        RX_PAUSE_VALID  = 1'b0;
        RX_PAUSE_QUANTA = '0;
    endtask

    initial begin
        RST             = 1'b1;
        GIG_MODE        = 1'b1;
        TX_PAUSE_ENABLE = 1'b1;
        TX_ACTIVE       = '0;
        idle_rx();
`ifdef AQ_GEMAC_PFC_STATS_EN
        STAT_SEL = 3'd0;
        STAT_CLR = 1'b0;
`endif
        step(3);
        chk("reset_apply", 32'(PAUSE_APPLY), 32'h00);
        chk("reset_any", 32'(PAUSE_ANY), 32'h0);
        chk("reset_done", 32'(PAUSE_LOAD_DONE), 32'h0);
        RST = 1'b0;
        cyc = 0;  // prescaler is 0 after the last reset edge; ticks land on cyc % 64 == 0

        // PFC load on idle class 3, quanta 2 at prescaler phase 0
        set_pfc(8'h08, 3, 16'd2);
        step(1);
        idle_rx();
        chk("pfc_done_pulse", 32'(PAUSE_LOAD_DONE), 32'h1);
        chk("pfc_apply_n", 32'(PAUSE_APPLY), 32'h00);
        step(1);
        chk("pfc_apply_n1", 32'(PAUSE_APPLY), 32'h08);
        chk("pfc_any", 32'(PAUSE_ANY), 32'h1);
        chk("pfc_done_clear", 32'(PAUSE_LOAD_DONE), 32'h0);
        step(125);
        chk("pfc_hold_127", 32'(PAUSE_APPLY), 32'h08);
        step(1);
        chk("pfc_hold_128", 32'(PAUSE_APPLY), 32'h08);
        step(1);
        chk("pfc_release_129", 32'(PAUSE_APPLY), 32'h00);
        chk("pfc_any_release", 32'(PAUSE_ANY), 32'h0);

        // Deferral while class 1 is transmitting
        TX_ACTIVE = 8'h02;
        set_pfc(8'h02, 1, 16'd10);
        step(1);
        idle_rx();
        chk("defer_after_load", 32'(PAUSE_APPLY), 32'h00);
        step(19);
        chk("defer_20_cycles", 32'(PAUSE_APPLY), 32'h00);
        TX_ACTIVE = 8'h00;
        step(1);
        chk("defer_rise", 32'(PAUSE_APPLY), 32'h02);
        set_pfc(8'h02, 1, 16'd0);
        step(1);
        idle_rx();
        chk("zero_load_done", 32'(PAUSE_LOAD_DONE), 32'h1);
        chk("zero_load_hold", 32'(PAUSE_APPLY), 32'h02);
        step(1);
        chk("zero_load_release", 32'(PAUSE_APPLY), 32'h00);

        // Override: 100 quanta replaced by 0 fifty cycles later
        set_pfc(8'h01, 0, 16'd100);
        step(1);
        idle_rx();
        step(1);
        chk("ovr_apply", 32'(PAUSE_APPLY), 32'h01);
        step(48);
        set_pfc(8'h01, 0, 16'd0);
        step(1);
        idle_rx();
        chk("ovr_hold", 32'(PAUSE_APPLY), 32'h01);
        step(1);
        chk("ovr_release", 32'(PAUSE_APPLY), 32'h00);

        // Legacy PAUSE loads every class
        RX_PAUSE_VALID  = 1'b1;
        RX_PAUSE_QUANTA = 16'd5;
        step(1);
        idle_rx();
        chk("legacy_done", 32'(PAUSE_LOAD_DONE), 32'h1);
        chk("legacy_apply_n", 32'(PAUSE_APPLY), 32'h00);
        step(1);
        chk("legacy_apply", 32'(PAUSE_APPLY), 32'hFF);
        chk("legacy_any", 32'(PAUSE_ANY), 32'h1);

        // Simultaneous PFC (class 0 = 1) and legacy (7): only class 0 expires at the next tick
        set_pfc(8'h01, 0, 16'd1);
        RX_PAUSE_VALID  = 1'b1;
        RX_PAUSE_QUANTA = 16'd7;
        step(1);
        idle_rx();
        do step(1); while (cyc % 64 != 0);
        chk("both_at_tick", 32'(PAUSE_APPLY), 32'hFF);
        step(1);
        chk("both_after_tick", 32'(PAUSE_APPLY), 32'hFE);

        // Disable clears everything
        TX_PAUSE_ENABLE = 1'b0;
        step(1);
        chk("dis_first_edge", 32'(PAUSE_APPLY), 32'hFE);
        step(1);
        chk("dis_second_edge", 32'(PAUSE_APPLY), 32'h00);
        TX_PAUSE_ENABLE = 1'b1;

        // MII mode: mode change restarts prescaler, period 128
        GIG_MODE = 1'b0;
        step(1);
        cyc = 0;
        set_pfc(8'h01, 0, 16'd1);
        step(1);
        idle_rx();
        step(1);
        chk("mii_apply", 32'(PAUSE_APPLY), 32'h01);
        step(126);
        chk("mii_hold_128", 32'(PAUSE_APPLY), 32'h01);
        step(1);
        chk("mii_release_129", 32'(PAUSE_APPLY), 32'h00);

        // Enable drop mid-count, then loads are ignored while disabled
        set_pfc(8'h01, 0, 16'd50);
        step(1);
        idle_rx();
        step(1);
        chk("en_apply", 32'(PAUSE_APPLY), 32'h01);
        step(10);
        TX_PAUSE_ENABLE = 1'b0;
        step(1);
        chk("en_drop_edge1", 32'(PAUSE_APPLY), 32'h01);
        step(1);
        chk("en_drop_edge2", 32'(PAUSE_APPLY), 32'h00);
        set_pfc(8'hFF, 0, 16'd9);
        RX_PAUSE_VALID  = 1'b1;
        RX_PAUSE_QUANTA = 16'd9;
        step(1);
        idle_rx();
        chk("dis_no_done", 32'(PAUSE_LOAD_DONE), 32'h0);
        step(1);
        chk("dis_no_apply", 32'(PAUSE_APPLY), 32'h00);
        TX_PAUSE_ENABLE = 1'b1;
        step(2);
        chk("reenable_no_apply", 32'(PAUSE_APPLY), 32'h00);

        // Reset mid-count
        RX_PAUSE_VALID  = 1'b1;
        RX_PAUSE_QUANTA = 16'd3;
        step(1);
        idle_rx();
        step(1);
        chk("pre_reset_apply", 32'(PAUSE_APPLY), 32'hFF);
        RST = 1'b1;
        step(1);
        chk("midrst_apply", 32'(PAUSE_APPLY), 32'h00);
        chk("midrst_any", 32'(PAUSE_ANY), 32'h0);
        RST = 1'b0;
        step(2);
        chk("post_rst_apply", 32'(PAUSE_APPLY), 32'h00);

`ifdef AQ_GEMAC_PFC_STATS_EN
        // Three nonzero loads and one zero load on class 2
        for (int k = 0; k < 3; k++) begin
            set_pfc(8'h04, 2, 16'd1);
            step(1);
            idle_rx();
            step(1);
        end
        set_pfc(8'h04, 2, 16'd0);
        step(1);
        idle_rx();
        STAT_SEL = 3'd2;
        step(2);
        chk("stat_cls2", 32'(STAT_DATA), 32'd3);
        STAT_SEL = 3'd0;
        step(2);
        chk("stat_cls0", 32'(STAT_DATA), 32'd0);
        STAT_CLR = 1'b1;
        step(1);
        STAT_CLR = 1'b0;
        STAT_SEL = 3'd2;
        step(1);
        chk("stat_clr", 32'(STAT_DATA), 32'd0);
        force dut.stat_cnt_q = '1;
        step(1);
        release dut.stat_cnt_q;
        set_pfc(8'h04, 2, 16'd1);
        step(1);
        idle_rx();
        step(1);
        chk("stat_saturate", 32'(STAT_DATA), 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
